sort_scheduler: RTL and testbench
=================================

SORT_SCHEDULER -- requirements
Module: sort_scheduler

Interface
REQ-001 The block SHALL take parameter WIDTH, default 32, as the element width in bits; it must be a multiple of 8.
REQ-002 The block SHALL take parameter DEPTH, default 8, as the number of elements per sequence.
REQ-003 The block SHALL take parameter QDEPTH, default 10, as the number of whole sequences the input queue holds.
REQ-004 clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  is the reset; it SHALL be asynchronous and active-low.
REQ-006 in_valid  input  1  SHALL be a one-cycle strobe marking in_array as a sequence to queue.
REQ-007 in_array  input  WIDTH x [DEPTH]  SHALL carry the sequence from the receive buffer.
REQ-008 sort_start  output  1  SHALL pulse to launch the sorter.
REQ-009 sort_array_out  output  WIDTH x [DEPTH]  SHALL carry the unsorted sequence presented to the sorter.
REQ-010 sort_done  input  1  SHALL be a one-cycle strobe marking sort_array_in as valid.
REQ-011 sort_array_in  input  WIDTH x [DEPTH]  SHALL carry the sorted result.
REQ-012 tx_valid / tx_byte / tx_ready  output 1 / output 8 / input 1  SHALL form the byte stream to the UART transmitter.
REQ-013 busy  output  1  SHALL be high whenever the FSM is not IDLE.
REQ-014 overflow  output  1  SHALL be a sticky flag for a dropped sequence.
REQ-015 seq_count  output  16  SHALL count fully transmitted sequences.

Function
REQ-016 The queue SHALL be a FIFO of QDEPTH sequences; every in_valid cycle SHALL push in_array, including back-to-back cycles.
REQ-017 A push when the queue holds QDEPTH entries SHALL drop the sequence, set overflow, and leave the queue contents unchanged.
REQ-018 A simultaneous push and pop on a full queue SHALL accept the push, with no overflow.
REQ-019 FSM states SHALL be IDLE, START, WAIT_SORT and SEND.
REQ-020 In IDLE with the queue non-empty, the FSM SHALL pop the head into the sort_array_out register and go to START on the same edge.
REQ-021 sort_start SHALL be high for exactly the one cycle spent in START; the next state SHALL be WAIT_SORT.
REQ-022 sort_array_out SHALL be held stable from START until the next pop.
REQ-023 In WAIT_SORT, sort_done SHALL capture sort_array_in into a tx register, clear the byte counter, and move to SEND.
REQ-024 sort_done in any state other than WAIT_SORT SHALL be ignored.
REQ-025 In SEND, tx_valid SHALL be high.
REQ-026 tx_byte for byte index b SHALL be element b/(WIDTH/8), bits 8*(b mod (WIDTH/8)) upward: element 0 first, little-endian within an element.
REQ-027 tx_byte SHALL hold stable while tx_valid is high and tx_ready is low.
REQ-028 Each cycle with tx_valid and tx_ready both high SHALL advance b.
REQ-029 On acceptance of the last byte (b = DEPTH*WIDTH/8 - 1), the FSM SHALL go to IDLE, drop tx_valid the next cycle, and increment seq_count, which wraps from 0xFFFF to 0.
REQ-030 Minimum latency SHALL be: in_valid sampled at edge N with the FSM IDLE and the queue empty gives sort_start high in the cycle after edge N+1.
REQ-031 Queue pushes SHALL continue in every FSM state.
REQ-032 A new pop SHALL occur only from IDLE, so at most one sequence is in flight.

Reset
REQ-033 While rst is low, state SHALL be IDLE, the queue empty, and the byte counter 0.
REQ-034 While rst is low, sort_start, tx_valid, busy and overflow SHALL be 0; tx_byte, sort_array_out and seq_count SHALL be 0.
REQ-035 Reset assertion mid-SEND or mid-WAIT_SORT SHALL abort the transfer immediately, with no further tx_valid.
REQ-036 A sort_done arriving during reset or in the cycle after deassertion SHALL be ignored.

Verification
REQ-037 Single sequence: in_valid with {8,7,6,5,4,3,2,1}; sorter returns {1..8} 5 cycles after sort_start; tx_ready held 1 -> sort_start 2 cycles after in_valid; 32 bytes 01 00 00 00 02 00 ... 08 00 00 00; busy low after; seq_count=1.
REQ-038 Burst: 10 back-to-back in_valid strobes -> exactly 10 sort_start pulses, in arrival order; overflow=0; seq_count=10.
REQ-039 Overflow: 11 back-to-back strobes while sort_done is withheld -> overflow=1; after releasing the sorter, exactly 10 sequences are sent and the 11th is absent.
REQ-040 Backpressure: tx_ready toggled 1,0,0,1 repeatedly -> no byte lost or duplicated; tx_byte stable during every stall; 32 bytes total.
REQ-041 Reset mid-SEND: assert rst after byte 5 -> tx_valid drops asynchronously; queue empty; overflow=0; seq_count=0; a new sequence after release is transmitted in full.
REQ-042 Spurious sort_done in IDLE and in SEND -> no state change and tx data unaffected.

Source files
------------

// File: rtl/sort_scheduler.sv
// Queues incoming sequences, hands them one at a time to an external sorter,
// then streams the sorted result out as bytes (element 0 first, little-endian).
module sort_scheduler #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned QDEPTH = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [DEPTH*WIDTH-1:0] in_array,
  output logic                   sort_start,
  output logic [DEPTH*WIDTH-1:0] sort_array_out,
  input  logic                   sort_done,
  input  logic [DEPTH*WIDTH-1:0] sort_array_in,
  output logic                   tx_valid,
  output logic [7:0]             tx_byte,
  input  logic                   tx_ready,
  output logic                   busy,
  output logic                   overflow,
  output logic [15:0]            seq_count
);

  localparam int unsigned DW     = DEPTH * WIDTH;
  localparam int unsigned NBYTES = DW / 8;
  localparam int unsigned BW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int unsigned QW     = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CW     = $clog2(QDEPTH + 1);

  typedef enum logic [1:0] {IDLE, START, WAIT_SORT, SEND} state_t;

  state_t          state, state_next;
  logic [DW-1:0]   mem [QDEPTH];
  logic [QW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;
  logic [DW-1:0]   tx_data;
  logic [BW-1:0]   byte_idx;
  logic            full, pop, push, load, advance, last_byte;

  assign full      = (count == CW'(QDEPTH));
  assign pop       = (state == IDLE) && (count != '0);
  // A pop on the same edge frees a slot, so a full queue still accepts.
  assign push      = in_valid && (!full || pop);
  assign load      = (state == WAIT_SORT) && sort_done;
  assign advance   = (state == SEND) && tx_ready;
  assign last_byte = (byte_idx == BW'(NBYTES - 1));

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (pop) state_next = START;
      START:     state_next = WAIT_SORT;
      WAIT_SORT: if (sort_done) state_next = SEND;
      SEND:      if (tx_ready && last_byte) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // State register with status outputs registered alongside it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      sort_start <= 1'b0;
      tx_valid   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_next;
      sort_start <= (state_next == START);
      tx_valid   <= (state_next == SEND);
      busy       <= (state_next != IDLE);
    end
  end

  // Queue storage carries no reset; occupancy is tracked by the pointers
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_array;
  end

  // Queue pointers, occupancy, sticky overflow and sorter operand
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      count          <= '0;
      overflow       <= 1'b0;
      sort_array_out <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == QW'(QDEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr         <= (rd_ptr == QW'(QDEPTH - 1)) ? '0 : rd_ptr + 1'b1;
        sort_array_out <= mem[rd_ptr];
      end
      if (in_valid && !push) overflow <= 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Transmit shifter: the next byte always sits in the low 8 bits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_data   <= '0;
      byte_idx  <= '0;
      seq_count <= '0;
    end else if (load) begin
      tx_data  <= sort_array_in;
      byte_idx <= '0;
    end else if (advance) begin
      tx_data  <= tx_data >> 8;
      byte_idx <= byte_idx + 1'b1;
      if (last_byte) seq_count <= seq_count + 16'd1;
    end
  end

  assign tx_byte = tx_data[7:0];

endmodule

// File: tb/tb_sort_scheduler.sv
// Randomized bench for sort_scheduler against a queue-based reference model
// with a behavioural sorter that answers a fixed number of cycles after each start.
module tb_sort_scheduler;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned QDEPTH = 10;
  localparam int unsigned DW     = WIDTH * DEPTH;
  localparam int unsigned BPE    = WIDTH / 8;
  localparam int unsigned NB     = DW / 8;
  localparam int unsigned LAT    = 5;

  typedef logic [DW-1:0] seq_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid = 1'b0;
  seq_t        in_array = '0;
  logic        sort_start;
  seq_t        sort_array_out;
  logic        sort_done = 1'b0;
  seq_t        sort_array_in = '0;
  logic        tx_valid;
  logic [7:0]  tx_byte;
  logic        tx_ready = 1'b1;
  logic        busy;
  logic        overflow;
  logic [15:0] seq_count;

  always #5 clk = ~clk;

  sort_scheduler #(.WIDTH(WIDTH), .DEPTH(DEPTH), .QDEPTH(QDEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_array(in_array),
    .sort_start(sort_start), .sort_array_out(sort_array_out),
    .sort_done(sort_done), .sort_array_in(sort_array_in),
    .tx_valid(tx_valid), .tx_byte(tx_byte), .tx_ready(tx_ready),
    .busy(busy), .overflow(overflow), .seq_count(seq_count)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input seq_t got, input seq_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: queue of accepted sequences plus flags for the one in flight
  seq_t       mq[$];
  logic [7:0] exp_bytes[$];
  logic [7:0] got_bytes[$];
  bit         m_idle, m_started, m_wait, m_send, m_ovf;
  int         m_seqcnt;
  seq_t       m_cur;

  bit   sorter_on = 1'b1;
  bit   pend;
  int   cd;
  seq_t pend_arr;

  int rdy_mode = 0;
  int rdy_i = 0;
  bit spur = 1'b0;
  int cyc = 0;
  int starts = 0;
  int accepted = 0;

  function automatic seq_t rand_seq();
    seq_t r;
    for (int i = 0; i < int'(DW / 32); i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic seq_t sort_seq(input seq_t s);
    logic [WIDTH-1:0] e[DEPTH];
    logic [WIDTH-1:0] t;
    seq_t r;
    for (int i = 0; i < int'(DEPTH); i++) e[i] = s[i*WIDTH +: WIDTH];
    for (int i = 0; i < int'(DEPTH) - 1; i++)
      for (int j = 0; j < int'(DEPTH) - 1 - i; j++)
        if (e[j] > e[j+1]) begin t = e[j]; e[j] = e[j+1]; e[j+1] = t; end
    for (int i = 0; i < int'(DEPTH); i++) r[i*WIDTH +: WIDTH] = e[i];
    return r;
  endfunction

  task automatic model_reset();
    mq.delete(); exp_bytes.delete();
    m_idle = 1'b1; m_started = 1'b0; m_wait = 1'b0; m_send = 1'b0; m_ovf = 1'b0;
    m_seqcnt = 0; m_cur = '0; pend = 1'b0; cd = 0;
  endtask

  // Predict the effect of the coming rising edge from the inputs now applied
  task automatic model_edge();
    bit pop_now;
    pop_now = m_idle && (mq.size() > 0);
    if (m_wait && sort_done) begin
      m_wait = 1'b0; m_send = 1'b1; exp_bytes.delete();
      for (int b = 0; b < int'(NB); b++)
        exp_bytes.push_back(sort_array_in[(b / BPE) * WIDTH + 8 * (b % BPE) +: 8]);
    end else if (m_send && tx_ready) begin
      got_bytes.push_back(tx_byte);
      void'(exp_bytes.pop_front());
      accepted++;
      if (exp_bytes.size() == 0) begin
        m_send = 1'b0; m_idle = 1'b1; m_seqcnt++;
      end
    end
    if (m_started) begin m_started = 1'b0; m_wait = 1'b1; end
    if (pop_now) begin m_cur = mq.pop_front(); m_idle = 1'b0; m_started = 1'b1; end
    if (in_valid) begin
      if (mq.size() < QDEPTH) mq.push_back(in_array);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic check_outputs();
    check("sort_start", sort_start, m_started);
    check("sort_array_out", sort_array_out, m_cur);
    if (m_started) begin
      starts++; pend = 1'b1; cd = LAT; pend_arr = m_cur;
    end
    check("busy", busy, !m_idle);
    check("tx_valid", tx_valid, m_send);
    if (m_send) check("tx_byte", tx_byte, exp_bytes[0]);
    check("overflow", overflow, m_ovf);
    check("seq_count", seq_count, 16'(m_seqcnt));
  endtask

  // One clock cycle: drive inputs at the falling edge, check at the next one
  task automatic step();
    cyc++;
    case (rdy_mode)
      0:       tx_ready = 1'b1;
      1:       begin tx_ready = (rdy_i % 4 == 0) || (rdy_i % 4 == 3); rdy_i++; end
      default: tx_ready = 1'($urandom_range(0, 1));
    endcase
    sort_done = spur;
    sort_array_in = spur ? rand_seq() : '0;
    if (pend && sorter_on) begin
      if (cd == 0) begin
        sort_done = 1'b1; sort_array_in = sort_seq(pend_arr); pend = 1'b0;
      end else cd--;
    end
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    in_valid = 1'b0;
    spur = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((!m_idle || mq.size() > 0) && n < budget) begin step(); n++; end
    check("drain_idle", m_idle && (mq.size() == 0), 1);
  endtask

  task automatic push_seq(input seq_t s);
    in_valid = 1'b1; in_array = s; step();
  endtask

  // Reset with sort_done held high throughout and in the first cycle after release
  task automatic do_reset();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check("rst_tx_valid", tx_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sort_start", sort_start, 0);
    model_reset();
    sort_done = 1'b1; sort_array_in = rand_seq();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_sort_array_out", sort_array_out, 0);
    check("rst_tx_byte", tx_byte, 0);
    check("rst_seq_count", seq_count, 0);
    check("rst_overflow", overflow, 0);
    rst = 1'b1; spur = 1'b1;
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, acc0, t_in, n;
    seq_t s;
    rst = 1'b0;
    do_reset();

    // Single known sequence {8..1}; sorter returns {1..8}
    for (int i = 0; i < int'(DEPTH); i++) s[i*WIDTH +: WIDTH] = WIDTH'(8 - i);
    got_bytes.delete(); s0 = starts;
    push_seq(s); t_in = cyc;
    n = 0;
    while (starts == s0 && n < 20) begin step(); n++; end
    // in_valid occupies the cycle before the push edge, so add one cycle
    check("start_latency", cyc - t_in + 1, 2);
    drain(500);
    check("single_nbytes", got_bytes.size(), NB);
    for (int b = 0; b < int'(NB) && b < got_bytes.size(); b++)
      check("single_byte", got_bytes[b], (b % BPE == 0) ? (b / BPE + 1) : 0);
    check("single_busy", busy, 0);
    check("single_seq_count", seq_count, 1);

    // Burst of 10 back-to-back strobes
    s0 = starts;
    for (int i = 0; i < 10; i++) push_seq(rand_seq());
    drain(2000);
    check("burst_starts", starts - s0, 10);
    check("burst_overflow", overflow, 0);
    check("burst_seq_count", seq_count, 11);

    // One sequence held at the sorter, then 11 more strobes: the last is dropped
    s0 = starts; sorter_on = 1'b0;
    push_seq(rand_seq()); step(); step(); step();
    for (int i = 0; i < 11; i++) push_seq(rand_seq());
    check("ovf_flag", overflow, 1);
    sorter_on = 1'b1;
    drain(3000);
    check("ovf_starts", starts - s0, 11);
    check("ovf_seq_count", seq_count, 22);

    // Backpressure pattern 1,0,0,1
    rdy_mode = 1; rdy_i = 0; acc0 = accepted;
    push_seq(rand_seq());
    drain(1000);
    check("bp_bytes", accepted - acc0, NB);
    rdy_mode = 0;

    // Reset after five bytes of a transfer
    acc0 = accepted;
    push_seq(rand_seq());
    n = 0;
    while (accepted - acc0 < 5 && n < 100) begin step(); n++; end
    check("pre_rst_tx_valid", tx_valid, 1);
    do_reset();
    acc0 = accepted;
    push_seq(rand_seq());
    drain(500);
    check("post_rst_bytes", accepted - acc0, NB);
    check("post_rst_seq_count", seq_count, 1);

    // Spurious sort_done in IDLE and in SEND
    spur = 1'b1; step();
    check("spur_idle_busy", busy, 0);
    push_seq(rand_seq());
    n = 0;
    while (!m_send && n < 50) begin step(); n++; end
    step(); step();
    spur = 1'b1; step();
    drain(500);
    check("spur_seq_count", seq_count, 2);

    // Random traffic with random backpressure and gaps
    rdy_mode = 2;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 5) == 0) begin in_valid = 1'b1; in_array = rand_seq(); end
      step();
    end
    drain(6000);
    rdy_mode = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
